serial_paralelo_rx: RTL and testbench
=====================================

// Module: serial_paralelo_rx
// PURPOSE
//   Receive end of the serial link: deserialises the 1-bit stream from the parallel-to-serial
//   transmitter back into bytes. Runs entirely on clk_8f (one bit per clock, MSB first).
//   Aligns to the idle/comma symbol COM, then declares the link active and recovers data
//   bytes plus their valid flag. The transmitter sends COM whenever its valid_in is low.
// PARAMETERS
//   WIDTH       8      bits per symbol
//   COM         8'hBC  comma/idle symbol used for alignment and as the "not valid" filler
//   SYNC_COUNT  4      consecutive aligned COMs required before active asserts
// PORTS
//   clk_8f       in   1      bit clock; all logic on posedge
//   reset        in   1      synchronous, active-high
//   data_in      in   1      serial bit, MSB of each symbol first
//   data_out     out  WIDTH  last recovered symbol
//   valid_out    out  1      1 = data_out is a data byte; 0 = COM/idle or not yet active
//   active       out  1      link aligned and delivering symbols
//   byte_strobe  out  1      one-cycle pulse per recovered symbol while active
// BEHAVIOUR
//   Reset (dominates everything): sr=0, state=HUNT, bit_cnt=0, com_cnt=0; data_out=0,
//     valid_out=0, active=0, byte_strobe=0. sr resets to 0 so no false COM at start.
//   Shift: every cycle sr <= nxt, where nxt = {sr[WIDTH-2:0], data_in}.
//   bit_cnt: 0..WIDTH-1. Symbol boundary = HUNT match, or bit_cnt==WIDTH-1 in SYNC/ACTIVE.
//   All outputs are registered and updated on the boundary edge. Latency: data_out is
//     visible one clock after the LSB of its symbol is sampled.
//   FSM:
//     HUNT   bit-by-bit search. If nxt==COM: bit_cnt<=0, com_cnt<=1, goto SYNC.
//            Otherwise stay in HUNT; bit_cnt is held at 0.
//     SYNC   bit_cnt increments and wraps at WIDTH-1. At each boundary:
//            nxt==COM  -> com_cnt++; if com_cnt+1==SYNC_COUNT, goto ACTIVE and set active<=1.
//            nxt!=COM  -> com_cnt<=0, goto HUNT, with no partial credit.
//            No outputs change in SYNC except active on the transition.
//     ACTIVE at each boundary: data_out<=nxt, valid_out<=(nxt!=COM), byte_strobe<=1.
//            byte_strobe is 0 on all other cycles.
//            data_out and valid_out hold for the whole WIDTH-cycle symbol period, so a
//            clk_f-domain consumer can sample them.
//            active stays 1 until reset. There is no loss-of-lock detection.
//   Boundary cases:
//     COM emulated across data bytes in HUNT is accepted; the SYNC_COUNT check rejects it.
//     A non-COM symbol in SYNC forces HUNT, even after SYNC_COUNT-1 COMs.
//     Reset mid-symbol discards the partial symbol. Re-activation needs SYNC_COUNT new COMs.
//     SYNC_COUNT=1: the HUNT match itself goes directly to ACTIVE.
//   com_cnt width: $clog2(SYNC_COUNT+1). bit_cnt width: $clog2(WIDTH).
// TESTING
//   1 reset=1 for 3 clks with data_in=1 -> data_out=0, valid_out=0, active=0,
//     byte_strobe=0 throughout.
//   2 4x 0xBC, aligned from the first bit after reset -> active=1 one clk after bit 32;
//     then 0x01,0x02,0x03 -> data_out 01/02/03, each held 8 clks; valid_out=1;
//     exactly one byte_strobe per byte.
//   3 prefix bits 1,0,1 then 4x 0xBC then 0x5A -> lock at offset 3; active after bit 35;
//     data_out=5A, valid_out=1.
//   4 2x 0xBC, then 0x55, then 4x 0xBC -> active stays 0 through the 0x55;
//     active rises only after the final 4 COMs.
//   5 active link sending 0x10,0xBC,0x11 -> valid_out 1,0,1; data_out 10,BC,11.
//   6 reset=1 for one clk at bit 4 of an active byte -> next clk all outputs 0;
//     4x 0xBC again -> active=1.

Source files
------------

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: aligns a 1-bit MSB-first stream on the COM symbol,
// then delivers recovered symbols with a data/idle valid flag on clk_8f.
module serial_paralelo_rx #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] COM        = 8'hBC,
   parameter int               SYNC_COUNT = 4
) (
   input  logic             clk_8f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             active,
   output logic             byte_strobe
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = $clog2(SYNC_COUNT + 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
   localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_COUNT - 1);

   typedef enum logic [1:0] {
      HUNT,
      SYNC,
      ACTIVE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]    com_cnt_q, com_cnt_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             valid_out_q, valid_out_d;
   logic             active_q, active_d;
   logic             byte_strobe_q, byte_strobe_d;

   logic             boundary;
   logic             is_com;

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      sr_d          = {sr_q[WIDTH-2:0], data_in};
      is_com        = (sr_d == COM);
      boundary      = (bit_cnt_q == BIT_LAST);
      state_d       = state_q;
      bit_cnt_d     = boundary ? '0 : bit_cnt_q + BW'(1);
      com_cnt_d     = com_cnt_q;
      data_out_d    = data_out_q;
      valid_out_d   = valid_out_q;
      active_d      = active_q;
      byte_strobe_d = 1'b0;

      unique case (state_q)
         HUNT: begin
            bit_cnt_d = '0;
            if (is_com) begin
               com_cnt_d = CW'(1);
               if (SYNC_COUNT == 1) begin
                  state_d  = ACTIVE;
                  active_d = 1'b1;
               end else begin
                  state_d = SYNC;
               end
            end
         end
         SYNC: begin
            if (boundary) begin
               if (is_com) begin
                  com_cnt_d = com_cnt_q + CW'(1);
                  if (com_cnt_q == SYNC_LAST) begin
                     state_d  = ACTIVE;
                     active_d = 1'b1;
                  end
               end else begin
                  // A single bad symbol throws away all accumulated COM credit.
                  com_cnt_d = '0;
                  state_d   = HUNT;
               end
            end
         end
         ACTIVE: begin
            if (boundary) begin
               data_out_d    = sr_d;
               valid_out_d   = !is_com;
               byte_strobe_d = 1'b1;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_8f) begin
      if (reset) begin
         state_q       <= HUNT;
         sr_q          <= '0;
         bit_cnt_q     <= '0;
         com_cnt_q     <= '0;
         data_out_q    <= '0;
         valid_out_q   <= 1'b0;
         active_q      <= 1'b0;
         byte_strobe_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sr_q          <= sr_d;
         bit_cnt_q     <= bit_cnt_d;
         com_cnt_q     <= com_cnt_d;
         data_out_q    <= data_out_d;
         valid_out_q   <= valid_out_d;
         active_q      <= active_d;
         byte_strobe_q <= byte_strobe_d;
      end
   end

   assign data_out    = data_out_q;
   assign valid_out   = valid_out_q;
   assign active      = active_q;
   assign byte_strobe = byte_strobe_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed link scenarios plus random traffic, every cycle
// compared against a model that re-scans the bit history received since the last reset.
module tb_serial_paralelo_rx;

   localparam int         SYNC_COUNT = 4;
   localparam logic [7:0] COM        = 8'hBC;

   logic       clk_8f = 1'b0;
   logic       reset  = 1'b1;
   logic       data_in = 1'b1;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;
   logic       byte_strobe;

   int n_checks = 0;
   int n_fail   = 0;
   int strobes_seen = 0;

   bit bits[$];

   serial_paralelo_rx #(.WIDTH(8), .COM(COM), .SYNC_COUNT(SYNC_COUNT)) dut (
      .clk_8f     (clk_8f),
      .reset      (reset),
      .data_in    (data_in),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .active     (active),
      .byte_strobe(byte_strobe)
   );

   always #5 clk_8f = ~clk_8f;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // 8-bit window ending at bit index k; positions before the first bit read as 0.
   function automatic logic [7:0] win(int k);
      logic [7:0] w;
      w = '0;
      for (int i = k - 7; i <= k; i++) w = {w[6:0], (i >= 0) ? bits[i] : 1'b0};
      return w;
   endfunction

   // Find the lock point: the first COM whose next SYNC_COUNT-1 aligned windows are also
   // COM; on a failed aligned window the search resumes at the following bit. Symbols are
   // then every 8 bits after the lock point.
   function automatic void model(output logic act, output logic [7:0] dout,
                                 output logic vld, output logic stb);
      int  n    = bits.size();
      int  k    = 0;
      int  lock = -1;
      bit  pending = 0;
      act = 1'b0; dout = '0; vld = 1'b0; stb = 1'b0;
      while (k < n && lock < 0 && !pending) begin
         if (win(k) != COM) begin
            k++;
         end else begin
            int fail_at = -1;
            for (int j = 1; j < SYNC_COUNT; j++) begin
               int idx = k + 8 * j;
               if (idx >= n) begin
                  pending = 1;
                  break;
               end
               if (win(idx) != COM) begin
                  fail_at = idx;
                  break;
               end
            end
            if (!pending) begin
               if (fail_at >= 0) k = fail_at + 1;
               else lock = k + 8 * (SYNC_COUNT - 1);
            end
         end
      end
      if (lock >= 0) begin
         act = 1'b1;
         for (int p = lock + 8; p < n; p += 8) begin
            dout = win(p);
            vld  = (win(p) != COM);
            stb  = (p == n - 1);
         end
      end
   endfunction

   task automatic compare_outputs();
      logic       e_act, e_vld, e_stb;
      logic [7:0] e_dout;
      model(e_act, e_dout, e_vld, e_stb);
      check("active",      32'(active),      32'(e_act));
      check("data_out",    32'(data_out),    32'(e_dout));
      check("valid_out",   32'(valid_out),   32'(e_vld));
      check("byte_strobe", 32'(byte_strobe), 32'(e_stb));
   endtask

   task automatic send_bit(input logic b);
      data_in = b;
      @(posedge clk_8f);
      #1;
      bits.push_back(b);
      if (byte_strobe === 1'b1) strobes_seen++;
      compare_outputs();
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_coms(input int n);
      for (int i = 0; i < n; i++) send_byte(COM);
   endtask

   task automatic do_reset(input int cycles);
      reset   = 1'b1;
      data_in = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk_8f);
         #1;
         bits.delete();
         check("rst_data_out",    32'(data_out),    32'h0);
         check("rst_valid_out",   32'(valid_out),   32'h0);
         check("rst_active",      32'(active),      32'h0);
         check("rst_byte_strobe", 32'(byte_strobe), 32'h0);
      end
      reset = 1'b0;
   endtask

   initial begin
      #1;
      // Reset held for three clocks with the line idling high.
      do_reset(3);

      // Aligned lock from the first bit, then three data bytes.
      send_coms(4);
      check("lock_aligned", 32'(active), 32'h1);
      strobes_seen = 0;
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      check("data_last",    32'(data_out),     32'h03);
      check("strobe_count", 32'(strobes_seen), 32'd3);

      // Lock at a 3-bit offset.
      do_reset(1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_coms(4);
      check("lock_offset", 32'(active), 32'h1);
      send_byte(8'h5A);
      check("offset_data", 32'(data_out), 32'h5A);

      // Interrupted sync: the non-COM symbol removes all credit.
      do_reset(1);
      send_coms(2);
      send_byte(8'h55);
      check("no_lock_after_55", 32'(active), 32'h0);
      send_coms(3);
      check("no_lock_3_coms", 32'(active), 32'h0);
      send_coms(1);
      check("lock_after_4", 32'(active), 32'h1);

      // Valid flag follows data versus idle symbols.
      send_byte(8'h10);
      send_byte(COM);
      check("idle_valid", 32'(valid_out), 32'h0);
      send_byte(8'h11);
      check("data_valid", 32'(valid_out), 32'h1);

      // Reset in the middle of an active byte, then relock.
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      do_reset(1);
      send_coms(4);
      check("relock", 32'(active), 32'h1);
      send_byte(8'hC3);

      // Random traffic: random prefix, random pre-lock bytes, COM runs, random payload.
      for (int r = 0; r < 6; r++) begin
         do_reset(1);
         for (int i = $urandom_range(0, 7); i > 0; i--) send_bit(1'($urandom));
         for (int i = $urandom_range(0, 2); i > 0; i--) send_byte(8'($urandom));
         send_coms($urandom_range(2, 5));
         for (int i = 0; i < 12; i++)
            send_byte(($urandom_range(0, 3) == 0) ? COM : 8'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
